mac_lane_loader: RTL and testbench

Producer-side front end for the 8-input saturating neuron adder. Accepts a serial stream of signed 8-bit (activation, weight) pairs over a valid/ready handshake. Forms each scaled, saturated product and assembles eight of them, plus a bias, into one parallel lane vector. Presents that vector to the adder stage through a valid/ready output handshake, and holds it until the consumer takes it.

---
 rtl/mac_lane_loader.sv | 110 +++++++++++
 tb/tb_mac_lane_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_loader.sv
// Serial (activation, weight) pair loader: scales and saturates each product into a
// 64-bit lane vector plus bias for the 8-input adder. MAC_LANE_LOADER_ROUND_EN selects round-half-up.
module mac_lane_loader #(
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_act,
  input  logic [7:0]  s_wt,
  input  logic [7:0]  s_bias,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_lanes,
  output logic [7:0]  m_bias,
  output logic [2:0]  lane_idx
);

  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam int unsigned LANE_W  = 8;
  localparam int unsigned VEC_W   = 64;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned WIDE_W  = 17;
`ifdef MAC_LANE_LOADER_ROUND_EN
  localparam int unsigned RND_ADD = (2 ** FRAC_BITS) / 2;
`else
  localparam int unsigned RND_ADD = 0;
`endif

  logic                      state_q, state_d;
  logic [2:0]                lane_idx_q, lane_idx_d;
  logic [VEC_W-1:0]          lanes_q, lanes_d;
  logic [LANE_W-1:0]         bias_q, bias_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [WIDE_W-1:0]  prod_rnd;
  logic signed [WIDE_W-1:0]  prod_shr;
  logic [LANE_W-1:0]         lane_val;

  // Scaled, optionally rounded, saturated product of the current input pair.
  always_comb begin
    prod     = PROD_W'($signed(s_act)) * PROD_W'($signed(s_wt));
    prod_rnd = WIDE_W'(prod) + $signed(WIDE_W'(RND_ADD));
    prod_shr = prod_rnd >>> FRAC_BITS;
    if (prod_shr > 17'sd127) begin
      lane_val = 8'h7F;
    end else if (prod_shr < -17'sd128) begin
      lane_val = 8'h80;
    end else begin
      lane_val = prod_shr[LANE_W-1:0];
    end
  end

  // Next-state logic; clr outranks any handshake, including a beat offered in FILL.
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    lanes_d    = lanes_q;
    bias_d     = bias_q;
    if (clr) begin
      state_d    = FILL;
      lane_idx_d = 3'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid) begin
            lanes_d[{lane_idx_q, 3'b000} +: LANE_W] = lane_val;
            lane_idx_d = lane_idx_q + 3'd1;
            if (lane_idx_q == 3'd7) begin
              bias_d  = s_bias;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      lane_idx_q <= 3'd0;
      lanes_q    <= '0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      lanes_q    <= lanes_d;
      bias_q     <= bias_d;
    end
  end

  // s_ready is a pure decode of state and rst so upstream sees no path from s_valid/m_ready.
  assign s_ready  = ~rst & (state_q == FILL);
  assign m_valid  = (state_q == HOLD);
  assign m_lanes  = lanes_q;
  assign m_bias   = bias_q;
  assign lane_idx = lane_idx_q;

endmodule

// File: tb/tb_mac_lane_loader.sv
// Scoreboard bench for mac_lane_loader (FRAC_BITS=4); expectations follow MAC_LANE_LOADER_ROUND_EN.
module tb_mac_lane_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_act = 8'h00;
  logic [7:0]  s_wt = 8'h00;
  logic [7:0]  s_bias = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_lanes;
  logic [7:0]  m_bias;
  logic [2:0]  lane_idx;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [63:0] lanes;
    logic [7:0]  bias;
  } vec_t;

  vec_t exp_q[$];

  mac_lane_loader #(.FRAC_BITS(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wt(s_wt), .s_bias(s_bias),
    .m_valid(m_valid), .m_ready(m_ready), .m_lanes(m_lanes), .m_bias(m_bias),
    .lane_idx(lane_idx)
  );

  always #5 clk = ~clk;

  // Monitor: while a scored vector is presented, it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && m_valid && exp_q.size() > 0) begin
      total++;
      if ({m_lanes, m_bias} !== {exp_q[0].lanes, exp_q[0].bias}) begin
        bad++;
        $display("FAIL vec: got lanes=%h bias=%h want lanes=%h bias=%h",
                 m_lanes, m_bias, exp_q[0].lanes, exp_q[0].bias);
      end
      if (m_ready && !clr) void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got s_ready=0 want 1");
    end
  endtask

  task automatic send_beats(input int n, input logic [7:0] act, input logic [7:0] wt);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      s_valid = 1'b1;
      s_act   = act;
      s_wt    = wt;
      s_bias  = 8'hAA;
      step();
    end
    s_valid = 1'b0;
  endtask

  // Eight pairs, lane 0 in the low byte; optionally scored by the monitor.
  task automatic send_vec(input logic [63:0] acts, input logic [63:0] wts, input logic [7:0] bias,
                          input logic [63:0] exp_lanes, input bit score);
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      s_valid = 1'b1;
      s_act   = acts[8*i +: 8];
      s_wt    = wts[8*i +: 8];
      s_bias  = (i == 7) ? bias : 8'hAA;
      if (i == 7 && score) begin
        v.lanes = exp_lanes;
        v.bias  = bias;
        exp_q.push_back(v);
      end
      step();
    end
    s_valid = 1'b0;
  endtask

  logic [63:0] sat_exp;

  initial begin
`ifdef MAC_LANE_LOADER_ROUND_EN
    sat_exp = {8'hFF, 8'hE0, 8'h02, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h7F};
`else
    sat_exp = {8'hFE, 8'hE0, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h7F};
`endif
    // Reset state
    step(); step(); step();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_lanes", m_lanes, 64'd0);
    chk("rst_bias", 64'(m_bias), 64'd0);
    chk("rst_idx", 64'(lane_idx), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Basic fill: 16*32=512 >>> 4 = 32
    m_ready = 1'b1;
    send_vec({8{8'd16}}, {8{8'd32}}, 8'd5, {8{8'h20}}, 1'b1);
    chk("basic_m_valid", 64'(m_valid), 64'd1);
    chk("basic_idx", 64'(lane_idx), 64'd0);
    step();
    chk("basic_after_m_valid", 64'(m_valid), 64'd0);
    chk("basic_after_s_ready", 64'(s_ready), 64'd1);

    // Saturation and rounding corners
    send_vec({8'hFF, 8'hF0, 8'h01, 8'hFF, 8'h03, 8'h80, 8'h80, 8'h7F},
             {8'd24, 8'd32, 8'd24, 8'd8, 8'd3, 8'h80, 8'd127, 8'd127},
             8'hFD, sat_exp, 1'b1);
    step();

    // Backpressure: vector held 20 cycles while upstream keeps offering data
    m_ready = 1'b0;
    send_vec({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8{8'd16}}, 8'd7,
             {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_act   = 8'(i + 40);
      s_wt    = 8'(i + 3);
      step();
      if (i % 5 == 0) chk("bp_s_ready", 64'(s_ready), 64'd0);
    end
    chk("bp_lanes", m_lanes, {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("bp_release_m_valid", 64'(m_valid), 64'd0);
    chk("bp_release_s_ready", 64'(s_ready), 64'd1);
    chk("bp_release_idx", 64'(lane_idx), 64'd0);
    m_ready = 1'b1;
    send_vec(64'h0A, {8{8'd16}}, 8'h22, 64'h0A, 1'b1);
    step();

    // Abort in FILL: clr beats s_valid
    send_beats(5, 8'd5, 8'd16);
    chk("abort_idx5", 64'(lane_idx), 64'd5);
    s_valid = 1'b1;
    s_act   = 8'd99;
    s_wt    = 8'd99;
    clr     = 1'b1;
    step();
    clr     = 1'b0;
    s_valid = 1'b0;
    chk("abort_idx", 64'(lane_idx), 64'd0);
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    send_vec({8{8'hF8}}, {8{8'd16}}, 8'h11, {8{8'hF8}}, 1'b1);
    step();

    // Abort in HOLD
    m_ready = 1'b0;
    send_vec({8{8'd1}}, {8{8'd16}}, 8'h33, {8{8'h01}}, 1'b0);
    chk("hold_m_valid", 64'(m_valid), 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("hold_clr_m_valid", 64'(m_valid), 64'd0);
    chk("hold_clr_s_ready", 64'(s_ready), 64'd1);
    chk("hold_clr_idx", 64'(lane_idx), 64'd0);

    // Reset mid-fill
    send_beats(3, 8'd2, 8'd16);
    chk("midrst_idx3", 64'(lane_idx), 64'd3);
    rst = 1'b1;
    step();
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_lanes", m_lanes, 64'd0);
    chk("midrst_bias", 64'(m_bias), 64'd0);
    chk("midrst_idx", 64'(lane_idx), 64'd0);
    rst = 1'b0;
    step();
    chk("midrst_after_s_ready", 64'(s_ready), 64'd1);

    step(); step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
